imem_refill: RTL and testbench

IMEM_REFILL -- requirements
Module: imem_refill

---
 rtl/imem_refill.sv | 134 +++++++++++++
 tb/tb_imem_refill.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_refill.sv
// Instruction-cache line refill engine: fetches LINE_WORDS words from instruction memory per miss.
// Define IMEM_CRITICAL_WORD_FIRST_EN to start at the missed word and wrap within the line.
module imem_refill #(
   parameter int LINE_WORDS = 4,
   parameter int TIMEOUT    = 255
) (
   input  logic                          CLK,
   input  logic                          RESET,
   input  logic                          REQ,
   input  logic [31:0]                   ADDR,
   output logic [31:0]                   RDATA,
   output logic                          RVALID,
   output logic [$clog2(LINE_WORDS)-1:0] RIDX,
   output logic                          DONE,
   output logic                          ERR,
   output logic                          BUSY,
   output logic                          MREQ,
   output logic [31:0]                   MADDR,
   input  logic [31:0]                   MRDATA,
   input  logic                          MACK
);
   localparam int IW = $clog2(LINE_WORDS);
   localparam int CW = IW + 1;

   typedef enum logic [1:0] {IDLE, FETCH, FIN, ABORT} state_t;

   state_t          state, next_state;
   logic [29-IW:0]  line_base, next_base;
   logic [IW-1:0]   idx, next_idx, start_idx;
   logic [CW-1:0]   word_cnt, next_cnt;
   logic [7:0]      tmo_cnt, next_tmo;

   logic [31:0]     next_rdata, next_maddr;
   logic [IW-1:0]   next_ridx;
   logic            next_rvalid, next_done, next_err, next_busy, next_mreq;
   logic            unused_addr_bits;

`ifdef IMEM_CRITICAL_WORD_FIRST_EN
   assign start_idx = ADDR[IW+1:2];
`else
   assign start_idx = '0;
`endif

   assign unused_addr_bits = ^ADDR[IW+1:0];

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state     <= IDLE;
         line_base <= '0;
         idx       <= '0;
         word_cnt  <= '0;
         tmo_cnt   <= '0;
         RDATA     <= '0;
         RVALID    <= 1'b0;
         RIDX      <= '0;
         DONE      <= 1'b0;
         ERR       <= 1'b0;
         BUSY      <= 1'b0;
         MREQ      <= 1'b0;
         MADDR     <= '0;
      end else begin
         state     <= next_state;
         line_base <= next_base;
         idx       <= next_idx;
         word_cnt  <= next_cnt;
         tmo_cnt   <= next_tmo;
         RDATA     <= next_rdata;
         RVALID    <= next_rvalid;
         RIDX      <= next_ridx;
         DONE      <= next_done;
         ERR       <= next_err;
         BUSY      <= next_busy;
         MREQ      <= next_mreq;
         MADDR     <= next_maddr;
      end
   end

   // Outputs are computed from the next state so every port comes straight from a flop.
   always_comb begin
      next_state  = state;
      next_base   = line_base;
      next_idx    = idx;
      next_cnt    = word_cnt;
      next_tmo    = tmo_cnt;
      next_rdata  = RDATA;
      next_ridx   = RIDX;
      next_rvalid = 1'b0;
      next_done   = 1'b0;
      next_err    = 1'b0;

      case (state)
         IDLE: begin
            if (REQ) begin
               next_base  = ADDR[31:IW+2];
               next_idx   = start_idx;
               next_cnt   = '0;
               next_tmo   = '0;
               next_state = FETCH;
            end
         end
         FETCH: begin
            if (MACK) begin
               next_rvalid = 1'b1;
               next_rdata  = MRDATA;
               next_ridx   = idx;
               next_idx    = idx + IW'(1);
               next_cnt    = word_cnt + CW'(1);
               next_tmo    = '0;
               if (word_cnt == CW'(LINE_WORDS - 1))
                  next_state = FIN;
            end else if (tmo_cnt == 8'(TIMEOUT - 1)) begin
               next_tmo   = '0;
               next_state = ABORT;
            end else begin
               next_tmo = tmo_cnt + 8'd1;
            end
         end
         FIN: begin
            next_done  = 1'b1;
            next_state = IDLE;
         end
         ABORT: begin
            next_err   = 1'b1;
            next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase

      // Index arithmetic is confined to IW bits, so the address can never leave the line.
      next_mreq  = (next_state == FETCH);
      next_busy  = (next_state != IDLE);
      next_maddr = next_mreq ? {next_base, next_idx, 2'b00} : 32'h0;
   end
endmodule

// File: tb/tb_imem_refill.sv
// Self-checking bench for imem_refill: directed vector table, hand-written corner sequences
// and randomized refills checked against a transaction-level model of the line refill.
module tb_imem_refill;
   localparam int LW  = 4;
   localparam int TMO = 8;
   localparam int IW  = 2;
`ifdef IMEM_CRITICAL_WORD_FIRST_EN
   localparam bit CWF = 1'b1;
`else
   localparam bit CWF = 1'b0;
`endif

   typedef int waits_t [LW];

   typedef struct packed {
      logic [31:0]     addr;
      logic [3:0][7:0] w;
      int              reset_after;
      bit              disturb;
      logic [31:0]     exp_first;
      int              exp_end;
      bit              exp_err;
   } vector_t;

   logic          clk = 1'b0;
   logic          reset;
   logic          req;
   logic [31:0]   addr;
   logic [31:0]   mrdata;
   logic          mack;
   logic [31:0]   rdata;
   logic          rvalid;
   logic [IW-1:0] ridx;
   logic          done;
   logic          err;
   logic          busy;
   logic          mreq;
   logic [31:0]   maddr;

   int n_checks = 0;
   int n_fail   = 0;

   vector_t vecs [8];
   string   vec_names [8];

   always #5 clk = ~clk;

   imem_refill #(.LINE_WORDS(LW), .TIMEOUT(TMO)) dut (
      .CLK(clk), .RESET(reset), .REQ(req), .ADDR(addr),
      .RDATA(rdata), .RVALID(rvalid), .RIDX(ridx), .DONE(done), .ERR(err), .BUSY(busy),
      .MREQ(mreq), .MADDR(maddr), .MRDATA(mrdata), .MACK(mack)
   );

   // Every comparison goes through here so the counts stay honest.
   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      n_checks++;
      if (actual !== expected) begin
         n_fail++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic checkAllZero(input string name);
      checkOutput({name, "_mreq"},   32'(mreq),   0);
      checkOutput({name, "_maddr"},  maddr,       0);
      checkOutput({name, "_rdata"},  rdata,       0);
      checkOutput({name, "_rvalid"}, 32'(rvalid), 0);
      checkOutput({name, "_ridx"},   32'(ridx),   0);
      checkOutput({name, "_done"},   32'(done),   0);
      checkOutput({name, "_err"},    32'(err),    0);
      checkOutput({name, "_busy"},   32'(busy),   0);
   endtask

   // Reference model: the refill is a list of LW word addresses starting at the critical word
   // (or word 0), each costing its wait cycles plus one accept cycle, followed by two cycles
   // of wind-down before DONE; a word waiting TMO cycles ends the refill with ERR instead.
   function automatic int modelStart(input logic [31:0] a);
      return CWF ? int'((a >> 2) % LW) : 0;
   endfunction

   function automatic logic [31:0] modelWordAddr(input logic [31:0] a, input int k);
      return (a & ~32'(LW * 4 - 1)) + 32'(((modelStart(a) + k) % LW) * 4);
   endfunction

   function automatic int modelRidx(input logic [31:0] a, input int k);
      return (modelStart(a) + k) % LW;
   endfunction

   function automatic int modelEnd(input waits_t w, output bit is_err, output int nwords);
      int acc = 0;
      is_err = 1'b0;
      nwords = LW;
      for (int k = 0; k < LW; k++) begin
         if (w[k] >= TMO) begin
            is_err = 1'b1;
            nwords = k;
            return acc + TMO + 2;
         end
         acc += w[k] + 1;
      end
      return acc + 2;
   endfunction

   // One complete refill: drives the cache and memory sides and checks every cycle.
   task automatic applyStimulus(input logic [31:0] a, input waits_t w, input int reset_after,
                                input bit disturb, output logic [31:0] first_maddr,
                                output int end_obs, output bit err_obs);
      int          exp_end, nwords, acked, wc, rv_cnt, done_cnt, err_cnt;
      bit          exp_err, ack_prev, seen_first, was_reset;
      logic [31:0] data_prev, d;

      exp_end     = modelEnd(w, exp_err, nwords);
      first_maddr = '0;
      end_obs     = -1;
      err_obs     = 1'b0;
      acked = 0; wc = 0; rv_cnt = 0; done_cnt = 0; err_cnt = 0;
      ack_prev = 1'b0; seen_first = 1'b0; was_reset = 1'b0;
      data_prev = '0;

      req = 1'b1; addr = a; mack = 1'b0; mrdata = $urandom;
      for (int cyc = 1; cyc <= exp_end + 1; cyc++) begin
         @(negedge clk);
         if (!seen_first && mreq) begin
            first_maddr = maddr;
            seen_first  = 1'b1;
         end
         checkOutput("busy", 32'(busy), 32'(cyc < exp_end));
         checkOutput("mreq", 32'(mreq), 32'(cyc <= exp_end - 2));
         if (mreq && acked < LW) begin
            checkOutput("maddr", maddr, modelWordAddr(a, acked));
            checkOutput("maddr_in_line", 32'(maddr[31:4]), 32'(a[31:4]));
         end
         checkOutput("rvalid", 32'(rvalid), 32'(ack_prev));
         if (rvalid && ack_prev && rv_cnt < LW) begin
            checkOutput("ridx",  32'(ridx), 32'(modelRidx(a, rv_cnt)));
            checkOutput("rdata", rdata, data_prev);
            rv_cnt++;
         end
         checkOutput("done", 32'(done), 32'(!exp_err && cyc == exp_end));
         checkOutput("err",  32'(err),  32'(exp_err && cyc == exp_end));
         if (done) begin
            done_cnt++;
            end_obs = cyc;
         end
         if (err) begin
            err_cnt++;
            end_obs = cyc;
            err_obs = 1'b1;
         end

         ack_prev = 1'b0;
         if (reset_after >= 0 && acked == reset_after) begin
            reset = 1'b1; mack = 1'b1; mrdata = $urandom; req = 1'b0;
            @(negedge clk);
            checkAllZero("reset_mid");
            reset = 1'b0; mack = 1'b0;
            for (int j = 0; j < 3; j++) begin
               @(negedge clk);
               checkOutput("post_reset_done", 32'(done), 0);
               checkOutput("post_reset_err",  32'(err),  0);
               checkOutput("post_reset_busy", 32'(busy), 0);
               if (done || err) end_obs = cyc;
            end
            was_reset = 1'b1;
            break;
         end

         if (cyc >= exp_end)  req = 1'b0;
         else if (disturb)    req = 1'($urandom_range(0, 1));
         else                 req = 1'b0;
         addr = disturb ? 32'hFFFF_FFF0 : $urandom;

         if (mreq && acked < LW) begin
            if (wc == w[acked]) begin
               d = $urandom;
               mack = 1'b1; mrdata = d; data_prev = d; ack_prev = 1'b1;
               acked++;
               wc = 0;
            end else begin
               mack = 1'b0; mrdata = $urandom;
               wc++;
            end
         end else begin
            mack   = 1'($urandom_range(0, 1));
            mrdata = $urandom;
         end
      end
      mack = 1'b0; req = 1'b0;

      if (!was_reset) begin
         checkOutput("rvalid_count", 32'(rv_cnt),   32'(nwords));
         checkOutput("done_count",   32'(done_cnt), 32'(exp_err ? 0 : 1));
         checkOutput("err_count",    32'(err_cnt),  32'(exp_err ? 1 : 0));
      end
   endtask

   function automatic logic [3:0][7:0] mkWaits(input int w0, input int w1, input int w2, input int w3);
      return {8'(w3), 8'(w2), 8'(w1), 8'(w0)};
   endfunction

   initial begin
      logic [31:0] first;
      int          end_obs, cnt;
      bit          err_obs;
      waits_t      w;

      // Directed vectors: expected first MADDR, DONE/ERR cycle and error flag per refill.
      vec_names[0] = "zero_wait";   vecs[0] = '{32'h0000_1238, mkWaits(0, 0, 0, 0),  -1, 1'b0,
                                               CWF ? 32'h0000_1238 : 32'h0000_1230,  6, 1'b0};
      vec_names[1] = "wait3";       vecs[1] = '{32'h0000_0040, mkWaits(3, 3, 3, 3),  -1, 1'b0,
                                               32'h0000_0040, 18, 1'b0};
      vec_names[2] = "timeout";     vecs[2] = '{32'h0000_0200, mkWaits(99, 0, 0, 0), -1, 1'b0,
                                               32'h0000_0200, 10, 1'b1};
      vec_names[3] = "reset_mid";   vecs[3] = '{32'h0000_0300, mkWaits(0, 1, 0, 0),   2, 1'b0,
                                               32'h0000_0300, -1, 1'b0};
      vec_names[4] = "after_reset"; vecs[4] = '{32'h0000_0080, mkWaits(0, 0, 0, 0),  -1, 1'b0,
                                               32'h0000_0080,  6, 1'b0};
      vec_names[5] = "disturb";     vecs[5] = '{32'h0000_0100, mkWaits(1, 0, 2, 0),  -1, 1'b1,
                                               32'h0000_0100,  9, 1'b0};
      vec_names[6] = "late_ack";    vecs[6] = '{32'h0000_0500, mkWaits(7, 0, 0, 0),  -1, 1'b0,
                                               32'h0000_0500, 13, 1'b0};
      vec_names[7] = "tmo_word2";   vecs[7] = '{32'h0000_1234, mkWaits(0, 0, 8, 0),  -1, 1'b0,
                                               CWF ? 32'h0000_1234 : 32'h0000_1230, 12, 1'b1};

      reset = 1'b1; req = 1'b0; addr = '0; mrdata = '0; mack = 1'b0;
      repeat (2) @(negedge clk);
      checkAllZero("reset_state");
      req = 1'b1; mack = 1'b1; addr = 32'h0000_1238;
      @(negedge clk);
      checkAllZero("reset_ignores_req");
      req = 1'b0; mack = 1'b0; reset = 1'b0;
      @(negedge clk);
      checkOutput("idle_busy", 32'(busy), 0);

      for (int v = 0; v < 8; v++) begin
         for (int k = 0; k < LW; k++) w[k] = int'(vecs[v].w[k]);
         applyStimulus(vecs[v].addr, w, vecs[v].reset_after, vecs[v].disturb, first, end_obs, err_obs);
         checkOutput({vec_names[v], "_first_maddr"}, first, vecs[v].exp_first);
         checkOutput({vec_names[v], "_end_cycle"},   32'(end_obs), 32'(vecs[v].exp_end));
         checkOutput({vec_names[v], "_err_flag"},    32'(err_obs), 32'(vecs[v].exp_err));
      end

      // REQ still high in the DONE cycle must launch the next refill straight away.
      req = 1'b1; addr = 32'h0000_0600; mack = 1'b0;
      for (int c = 1; c <= 7; c++) begin
         @(negedge clk);
         if (c == 6) checkOutput("b2b_done", 32'(done), 1);
         if (c == 7) begin
            checkOutput("b2b_restart_busy",  32'(busy), 1);
            checkOutput("b2b_restart_mreq",  32'(mreq), 1);
            checkOutput("b2b_restart_maddr", maddr, modelWordAddr(32'h0000_0600, 0));
         end
         mack = mreq; mrdata = $urandom;
      end
      req = 1'b0;
      cnt = 0;
      for (int c = 0; c < 20 && cnt == 0; c++) begin
         @(negedge clk);
         if (done) cnt++;
         mack = mreq; mrdata = $urandom;
      end
      checkOutput("b2b_second_done", 32'(cnt), 1);
      mack = 1'b0;
      @(negedge clk);
      checkOutput("b2b_idle_busy", 32'(busy), 0);

      // Randomized refills: random addresses, wait patterns, timeouts, resets and REQ noise.
      for (int t = 0; t < 25; t++) begin
         int ra;
         for (int k = 0; k < LW; k++)
            w[k] = ($urandom_range(0, 7) == 0) ? int'($urandom_range(TMO - 1, TMO + 2))
                                               : int'($urandom_range(0, 3));
         ra = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, LW - 1)) : -1;
         applyStimulus($urandom, w, ra, 1'($urandom_range(0, 1)), first, end_obs, err_obs);
         @(negedge clk);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation did not complete");
      $fatal(1, "[TB] watchdog expired");
   end
endmodule
